// File: rtl/busrq_arbiter.sv
// Two-master DMA arbiter for a Z80 bus: requests BUSRQ, then hands the bus to one
// master at a time, round-robin, with a burst limit that applies only under contention.
module busrq_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       cpu_busrq_n,
  input  logic       cpu_busack_n,
  output logic       owner,
  output logic       err
);

  // state   | meaning
  // IDLE    | bus left to the CPU, BUSRQ released
  // WAITACK | BUSRQ asserted, waiting for BUSACK
  // GRANT   | one master owns the bus, burst counter running
  // GAP     | one dead cycle between grants, BUSRQ still held
  typedef enum logic [1:0] {IDLE, WAITACK, GRANT, GAP} state_t;

  localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] gnt_nx;
  logic       busrq_nx, owner_nx, err_nx;
  logic       winner;

  // Contention goes to the master that did not hold the bus last.
  always_comb begin
    winner = owner;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~owner;
      default: winner = owner;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    busrq_nx = cpu_busrq_n;
    owner_nx = owner;
    err_nx   = err;
    case (state)
      IDLE: begin
        gnt_nx = 2'b00;
        if (|req) begin
          busrq_nx = 1'b0;
          state_nx = WAITACK;
        end else begin
          busrq_nx = 1'b1;
        end
      end
      WAITACK: begin
        gnt_nx = 2'b00;
        if (!cpu_busack_n) begin
          if (|req) begin
            gnt_nx   = winner ? 2'b10 : 2'b01;
            owner_nx = winner;
            cnt_nx   = 8'd0;
            state_nx = GRANT;
          end else begin
            state_nx = GAP;
          end
        end else if (req == 2'b00) begin
          busrq_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      GRANT: begin
        if (cpu_busack_n) begin
          gnt_nx   = 2'b00;
          err_nx   = 1'b1;
          busrq_nx = 1'b0;
          state_nx = WAITACK;
        end else if (!req[owner] || (cnt == LAST && req[~owner])) begin
          gnt_nx   = 2'b00;
          state_nx = GAP;
        end else if (cnt != LAST) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      GAP: begin
        gnt_nx = 2'b00;
        if (cpu_busack_n) begin
          err_nx   = 1'b1;
          busrq_nx = 1'b0;
          state_nx = WAITACK;
        end else if (|req) begin
          gnt_nx   = winner ? 2'b10 : 2'b01;
          owner_nx = winner;
          cnt_nx   = 8'd0;
          state_nx = GRANT;
        end else begin
          busrq_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        gnt_nx   = 2'b00;
        busrq_nx = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Reset wins over cen so a stalled block can still be cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      gnt         <= 2'b00;
      cpu_busrq_n <= 1'b1;
      owner       <= 1'b1;
      err         <= 1'b0;
    end else if (cen) begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      gnt         <= gnt_nx;
      cpu_busrq_n <= busrq_nx;
      owner       <= owner_nx;
      err         <= err_nx;
    end
  end

endmodule

// File: tb/tb_busrq_arbiter.sv
// Directed bench for busrq_arbiter: a default instance and a MAX_BURST=4 instance
// share the same stimulus; expected values are hand-derived per step.
module tb_busrq_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic [1:0] req = 2'b00;
  logic       cpu_busack_n = 1'b1;
  logic [1:0] gnt, gnt4;
  logic       cpu_busrq_n, busrq4_n;
  logic       owner, owner4;
  logic       err, err4;

  int checks = 0;
  int errors = 0;

  busrq_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .req(req), .gnt(gnt),
    .cpu_busrq_n(cpu_busrq_n), .cpu_busack_n(cpu_busack_n), .owner(owner), .err(err)
  );

  busrq_arbiter #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .req(req), .gnt(gnt4),
    .cpu_busrq_n(busrq4_n), .cpu_busack_n(cpu_busack_n), .owner(owner4), .err(err4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One enabled edge followed by two disabled ones; outputs must hold across the gap.
  task automatic cstep(input string tag, input logic [1:0] exp_gnt, input logic exp_busrq);
    cen = 1'b1;
    step();
    cen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk(tag, {6'd0, gnt}, {6'd0, exp_gnt});
      chk({tag, "_busrq"}, {7'd0, cpu_busrq_n}, {7'd0, exp_busrq});
      if (k < 2) step();
    end
    cen = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_gnt", {6'd0, gnt}, 8'h00);
    chk("rst_busrq", {7'd0, cpu_busrq_n}, 8'h01);
    chk("rst_owner", {7'd0, owner}, 8'h01);
    chk("rst_err", {7'd0, err}, 8'h00);
    rst_n = 1'b1;

    // request withdrawn before BUSACK: back to IDLE
    req = 2'b01;
    step();
    chk("wa_busrq_low", {7'd0, cpu_busrq_n}, 8'h00);
    req = 2'b00;
    step();
    chk("wa_abort_busrq", {7'd0, cpu_busrq_n}, 8'h01);
    chk("wa_abort_gnt", {6'd0, gnt}, 8'h00);

    // single request
    req = 2'b01;
    step();
    chk("single_busrq", {7'd0, cpu_busrq_n}, 8'h00);
    step();
    chk("single_nogrant", {6'd0, gnt}, 8'h00);
    cpu_busack_n = 1'b0;
    step();
    chk("single_gnt", {6'd0, gnt}, 8'h01);
    chk("single_owner", {7'd0, owner}, 8'h00);
    step();
    step();
    chk("single_hold", {6'd0, gnt}, 8'h01);
    req = 2'b00;
    step();
    chk("single_gap_gnt", {6'd0, gnt}, 8'h00);
    chk("single_gap_busrq", {7'd0, cpu_busrq_n}, 8'h00);
    step();
    chk("single_idle_busrq", {7'd0, cpu_busrq_n}, 8'h01);
    cpu_busack_n = 1'b1;
    step();
    chk("single_idle_gnt", {6'd0, gnt}, 8'h00);

    // contention from reset, forced release after 16 cycles
    do_reset();
    req = 2'b11;
    step();
    chk("cont_busrq", {7'd0, cpu_busrq_n}, 8'h00);
    cpu_busack_n = 1'b0;
    step();
    chk("cont_gnt0", {6'd0, gnt}, 8'h01);
    chk("cont_owner0", {7'd0, owner}, 8'h00);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("cont_hold0", {6'd0, gnt}, 8'h01);
      chk("cont_busrq_hold", {7'd0, cpu_busrq_n}, 8'h00);
    end
    step();
    chk("cont_gap", {6'd0, gnt}, 8'h00);
    chk("cont_gap_busrq", {7'd0, cpu_busrq_n}, 8'h00);
    step();
    chk("cont_gnt1", {6'd0, gnt}, 8'h10 >> 3);
    chk("cont_owner1", {7'd0, owner}, 8'h01);
    chk("cont_busrq_g1", {7'd0, cpu_busrq_n}, 8'h00);

    // reset mid-burst while gnt=10
    rst_n = 1'b0;
    step();
    chk("rstmid_gnt", {6'd0, gnt}, 8'h00);
    chk("rstmid_busrq", {7'd0, cpu_busrq_n}, 8'h01);
    chk("rstmid_owner", {7'd0, owner}, 8'h01);
    rst_n = 1'b1;
    req = 2'b00;
    cpu_busack_n = 1'b1;
    step();

    // contention with cen active one cycle in three
    do_reset();
    req = 2'b11;
    cstep("cen_busrq", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    cstep("cen_gnt0", 2'b01, 1'b0);
    for (int i = 1; i < 16; i++) cstep("cen_hold0", 2'b01, 1'b0);
    cstep("cen_gap", 2'b00, 1'b0);
    cstep("cen_gnt1", 2'b10, 1'b0);
    chk("cen_owner1", {7'd0, owner}, 8'h01);

    // reset is honoured with cen low
    cen = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rst_cenlow_gnt", {6'd0, gnt}, 8'h00);
    chk("rst_cenlow_busrq", {7'd0, cpu_busrq_n}, 8'h01);
    rst_n = 1'b1;
    cen = 1'b1;
    req = 2'b00;
    cpu_busack_n = 1'b1;
    step();

    // protocol error: BUSACK lost during GRANT
    do_reset();
    req = 2'b01;
    step();
    cpu_busack_n = 1'b0;
    step();
    chk("perr_gnt", {6'd0, gnt}, 8'h01);
    step();
    cpu_busack_n = 1'b1;
    step();
    chk("perr_gnt_drop", {6'd0, gnt}, 8'h00);
    chk("perr_err", {7'd0, err}, 8'h01);
    chk("perr_busrq", {7'd0, cpu_busrq_n}, 8'h00);
    cpu_busack_n = 1'b0;
    step();
    chk("perr_regrant", {6'd0, gnt}, 8'h01);
    chk("perr_err_sticky", {7'd0, err}, 8'h01);
    req = 2'b00;
    step();
    step();
    chk("perr_idle_busrq", {7'd0, cpu_busrq_n}, 8'h01);
    chk("perr_err_idle", {7'd0, err}, 8'h01);
    cpu_busack_n = 1'b1;
    do_reset();
    chk("perr_err_clr", {7'd0, err}, 8'h00);

    // no starvation with MAX_BURST=4 and a single requester
    req = 2'b01;
    step();
    cpu_busack_n = 1'b0;
    step();
    chk("nostarve_gnt", {6'd0, gnt4}, 8'h01);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("nostarve_hold", {6'd0, gnt4}, 8'h01);
    end
    // second master arrives: counter is saturated, so release is immediate
    req = 2'b11;
    step();
    chk("sat_release", {6'd0, gnt4}, 8'h00);
    step();
    chk("sat_switch", {6'd0, gnt4}, 8'h02);
    chk("sat_owner", {7'd0, owner4}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/busrq_arbiter.md
BUSRQ_ARBITER -- requirements
Module: busrq_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 16, range 2..256; number of cen cycles a holder keeps the grant before a forced release when the other requester is waiting.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 cen  in  1  clock enable; when low, all state, counters and outputs hold.
REQ-005 req  in  2  bus requests from the two DMA masters, active-high, level-sensitive.
REQ-006 gnt  out  2  bus grants, one-hot or zero, registered.
REQ-007 cpu_busrq_n  out  1  Z80 BUSRQ, active-low, registered.
REQ-008 cpu_busack_n  in  1  Z80 BUSACK, active-low.
REQ-009 owner  out  1  index of the last granted requester.
REQ-010 err  out  1  sticky protocol-error flag.

Function
REQ-011 The state machine SHALL have four states: IDLE, WAITACK, GRANT and GAP; all transitions occur only on edges where cen=1.
REQ-012 IDLE: with any req bit set, the block SHALL drive cpu_busrq_n=0 on the next edge and enter WAITACK; otherwise cpu_busrq_n=1 and gnt=0.
REQ-013 WAITACK with cpu_busack_n=0: the block SHALL pick a winner, set gnt for that winner on the same edge, load owner, clear the burst counter and enter GRANT.
REQ-014 WAITACK with req=0 and cpu_busack_n=1: the block SHALL drive cpu_busrq_n=1 and return to IDLE.
REQ-015 WAITACK with req=0 and cpu_busack_n=0: the block SHALL go to GAP with no grant.
REQ-016 Winner selection SHALL be round-robin: a sole requester wins; when both request, the index not equal to owner wins.
REQ-017 GRANT: the burst counter (8-bit, saturating at MAX_BURST-1) SHALL increment on every cen cycle.
REQ-018 GRANT SHALL exit to GAP and clear gnt when either condition holds: (a) req[owner]=0; (b) the counter equals MAX_BURST-1 and the other req bit is 1 (forced release).
REQ-019 If the counter reaches MAX_BURST-1 with no other requester pending, the holder SHALL keep the grant indefinitely.
REQ-020 GAP SHALL last exactly one cen cycle with gnt=0 and cpu_busrq_n=0.
REQ-021 GAP exit with any req set and cpu_busack_n=0: the block SHALL re-grant via REQ-016 and enter GRANT without releasing BUSRQ.
REQ-022 GAP exit with no req set: the block SHALL drive cpu_busrq_n=1 and go to IDLE.
REQ-023 cpu_busack_n returning to 1 while in GRANT or GAP is a protocol error: the block SHALL clear gnt, set err, keep cpu_busrq_n=0 and enter WAITACK.
REQ-024 The block SHALL never assert gnt while cpu_busack_n was sampled high on the same edge, and never assert both gnt bits at once.
REQ-025 A request dropped in the same cycle its grant is issued SHALL be handled as REQ-018a on the next edge.
REQ-026 Latency: req rising to cpu_busrq_n low is 1 cen cycle; cpu_busack_n low to gnt high is 1 cen cycle.

Reset
REQ-027 On rst_n=0 (sampled regardless of cen), the block SHALL set state=IDLE, gnt=0, cpu_busrq_n=1, counter=0, owner=1 and err=0, so that req[0] wins the first contention.
REQ-028 Reset asserted mid-grant SHALL drop gnt and BUSRQ on the same edge with no GAP cycle.

Verification
REQ-029 Single request: req=01, busack_n low 2 cycles after busrq_n falls -> gnt=01 one cycle after busack_n low; req=00 -> GAP 1 cycle, busrq_n=1, state IDLE.
REQ-030 Contention from reset: req=11 with busack_n low -> gnt=01, forced release after 16 cycles, one GAP cycle, then gnt=10, owner=1; busrq_n stays 0 throughout.
REQ-031 No starvation: MAX_BURST=4, req=01 only -> gnt=01 held for 50 cycles, no GAP.
REQ-032 Protocol error: busack_n forced high during GRANT -> gnt=00 next edge, err=1, state WAITACK; err stays 1 until reset.
REQ-033 cen gating: toggle cen 1-of-3 during scenario REQ-030 -> identical grant sequence, with every duration scaled by 3.
REQ-034 Reset mid-burst: rst_n=0 while gnt=10 -> gnt=00, busrq_n=1, owner=1 on that edge.
